// File: rtl/rtoc_ttl_out_driver.sv
// ---------------------------------------------------------------------------
// rtoc_ttl_out_driver
//
// Output stage placed after the real-time output FIFO core. Each cycle in
// which counter_matched is high carries a due event in rto_out. The low
// DATA_LEN bits of that word become the new logical channel levels. This
// block registers those levels onto the physical TTL pins and adds the
// following features:
//   * per-channel polarity inversion (logical -> physical),
//   * a software override of the physical pins,
//   * a minimum-hold guard that flags level changes arriving too soon,
//   * saturating per-channel rising-edge counters for readback.
//
// Ports
//   clk              system clock
//   reset            asynchronous, active-high reset
//   counter_matched  one-cycle strobe: rto_out carries a due event
//   rto_out[127:0]   event word: [127:64] timestamp, [DATA_LEN-1:0] levels
//   invert           per-channel physical polarity inversion
//   override_en      1 = pins driven from override_val
//   override_val     physical pin levels while override_en=1
//   count_clear      synchronous clear of all edge counters
//   ttl_out          registered physical pin levels
//   level            scheduled logical level (pre-invert, ignores override)
//   edge_count       flattened counters, channel c at [c*COUNT_WIDTH +: COUNT_WIDTH]
//   hold_error       one-cycle pulse on a minimum-hold violation
//   hold_error_data  rto_out word of the most recent violating event
//
// Interface note: there is no backpressure. counter_matched is a qualifier
// only. Every cycle in which it is high is consumed as one event, including
// consecutive cycles.
// ---------------------------------------------------------------------------
module rtoc_ttl_out_driver #(
    parameter int DATA_LEN    = 1,
    parameter int MIN_HOLD    = 4,
    parameter int COUNT_WIDTH = 32
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            counter_matched,
    input  logic [127:0]                    rto_out,
    input  logic [DATA_LEN-1:0]             invert,
    input  logic                            override_en,
    input  logic [DATA_LEN-1:0]             override_val,
    input  logic                            count_clear,
    output logic [DATA_LEN-1:0]             ttl_out,
    output logic [DATA_LEN-1:0]             level,
    output logic [DATA_LEN*COUNT_WIDTH-1:0] edge_count,
    output logic                            hold_error,
    output logic [127:0]                    hold_error_data
);

    // The hold counter needs a nonzero width even when the guard is
    // disabled. With MIN_HOLD=0 it is reloaded with zero, so it never
    // becomes busy.
    localparam int            HW          = (MIN_HOLD > 0) ? $clog2(MIN_HOLD + 1) : 1;
    localparam logic [HW-1:0] HOLD_RELOAD = (MIN_HOLD > 0) ? HW'(MIN_HOLD - 1) : '0;
    localparam logic [HW-1:0] HOLD_ONE    = HW'(1);
    localparam logic [COUNT_WIDTH-1:0] CNT_ONE = COUNT_WIDTH'(1);
    localparam bit            GUARD_ON    = (MIN_HOLD > 0);

    // State registers
    logic [DATA_LEN-1:0]    level_q, level_d;
    logic [DATA_LEN-1:0]    ttl_q, ttl_d;
    logic [HW-1:0]          hold_q [DATA_LEN];
    logic [HW-1:0]          hold_d [DATA_LEN];
    logic [COUNT_WIDTH-1:0] cnt_q  [DATA_LEN];
    logic [COUNT_WIDTH-1:0] cnt_d  [DATA_LEN];
    logic                   herr_q, herr_d;
    logic [127:0]           herr_data_q, herr_data_d;

    // Combinational helpers
    logic [DATA_LEN-1:0] change;     // channel's level changes this cycle
    logic [DATA_LEN-1:0] hold_busy;  // channel still inside its hold window
    logic [DATA_LEN-1:0] rise;       // logical 0->1 at the coming edge
    logic                violation;

    always_comb begin
        level_d     = level_q;
        ttl_d       = ttl_q;
        herr_d      = 1'b0;
        herr_data_d = herr_data_q;
        change      = '0;
        hold_busy   = '0;
        rise        = '0;
        violation   = 1'b0;

        if (counter_matched) begin
            level_d = rto_out[DATA_LEN-1:0];
            change  = rto_out[DATA_LEN-1:0] ^ level_q;
        end

        // The pin tracks the level being registered at this same edge. This
        // gives the pin the same one-cycle latency as the level register.
        // Override replaces only the pin value. Scheduling continues.
        if (override_en) begin
            ttl_d = override_val;
        end else begin
            ttl_d = level_d ^ invert;
        end

        for (int c = 0; c < DATA_LEN; c++) begin
            hold_busy[c] = (hold_q[c] != '0);
            if (change[c]) begin
                hold_d[c] = HOLD_RELOAD;
            end else if (hold_busy[c]) begin
                hold_d[c] = hold_q[c] - HOLD_ONE;
            end else begin
                hold_d[c] = hold_q[c];
            end
        end

        // A violating change is still applied. The guard only reports it.
        // Several channels violating together raise a single pulse.
        violation = GUARD_ON && (|(change & hold_busy));
        if (violation) begin
            herr_d      = 1'b1;
            herr_data_d = rto_out;
        end

        // The counters are logical. They follow level, not the pin, so
        // invert and override do not affect them.
        rise = level_d & ~level_q;
        for (int c = 0; c < DATA_LEN; c++) begin
            if (count_clear) begin
                cnt_d[c] = '0;
            end else if (rise[c] && !(&cnt_q[c])) begin
                cnt_d[c] = cnt_q[c] + CNT_ONE;
            end else begin
                cnt_d[c] = cnt_q[c];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            level_q     <= '0;
            ttl_q       <= '0;
            herr_q      <= 1'b0;
            herr_data_q <= '0;
            for (int c = 0; c < DATA_LEN; c++) begin
                hold_q[c] <= '0;
                cnt_q[c]  <= '0;
            end
        end else begin
            level_q     <= level_d;
            ttl_q       <= ttl_d;
            herr_q      <= herr_d;
            herr_data_q <= herr_data_d;
            for (int c = 0; c < DATA_LEN; c++) begin
                hold_q[c] <= hold_d[c];
                cnt_q[c]  <= cnt_d[c];
            end
        end
    end

    assign ttl_out         = ttl_q;
    assign level           = level_q;
    assign hold_error      = herr_q;
    assign hold_error_data = herr_data_q;

    for (genvar g = 0; g < DATA_LEN; g++) begin : g_cnt_flat
        assign edge_count[g*COUNT_WIDTH +: COUNT_WIDTH] = cnt_q[g];
    end

endmodule

// File: tb/tb_rtoc_ttl_out_driver.sv
module tb_rtoc_ttl_out_driver;

  localparam int DL = 2;
  localparam int MH = 4;
  localparam int CW = 4;

  logic            clk = 1'b0;
  logic            reset;
  logic            counter_matched;
  logic [127:0]    rto_out;
  logic [DL-1:0]   invert;
  logic            override_en;
  logic [DL-1:0]   override_val;
  logic            count_clear;
  logic [DL-1:0]   ttl_out;
  logic [DL-1:0]   level;
  logic [DL*CW-1:0] edge_count;
  logic            hold_error;
  logic [127:0]    hold_error_data;

  int pass_cnt  = 0;
  int total_cnt = 0;
  logic [63:0] ts = 64'h1000;

  rtoc_ttl_out_driver #(
    .DATA_LEN(DL), .MIN_HOLD(MH), .COUNT_WIDTH(CW)
  ) dut (
    .clk(clk), .reset(reset), .counter_matched(counter_matched),
    .rto_out(rto_out), .invert(invert), .override_en(override_en),
    .override_val(override_val), .count_clear(count_clear),
    .ttl_out(ttl_out), .level(level), .edge_count(edge_count),
    .hold_error(hold_error), .hold_error_data(hold_error_data)
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, actual=running required=finished");
    $fatal(1, "watchdog");
  end

  // driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One event cycle. Inputs are applied now and consumed at the next edge.
  // The bench then samples 1ns after that edge.
  task automatic ev(input logic [DL-1:0] v);
    ts = ts + 64'd17;
    counter_matched = 1'b1;
    rto_out = {ts, 62'd0, v};
    step();
    counter_matched = 1'b0;
  endtask

  task automatic do_reset();
    invert = '0;
    override_en = 1'b0;
    override_val = '0;
    count_clear = 1'b0;
    counter_matched = 1'b0;
    rto_out = '0;
    reset = 1'b1;
    step();
    reset = 1'b0;
    step();
  endtask

  task automatic test_reset();
    invert = '0; override_en = 1'b0; override_val = '0; count_clear = 1'b0;
    counter_matched = 1'b0; rto_out = '0;
    reset = 1'b1;
    step();
    total_cnt++;
    if ({ttl_out, level, edge_count, hold_error} !== '0 || hold_error_data !== '0) begin
      $display("FAIL reset_state: ttl=%b level=%b cnt=%h herr=%b hdata=%h required all zero",
               ttl_out, level, edge_count, hold_error, hold_error_data);
    end else pass_cnt++;
    reset = 1'b0;
    repeat (3) step();
    ev(2'b01);
    total_cnt++;
    if (ttl_out !== 2'b01 || level !== 2'b01) begin
      $display("FAIL reset_pre_event: ttl=%b level=%b required 01/01", ttl_out, level);
    end else pass_cnt++;
    repeat (3) step();
    // Assert reset between edges. The outputs must clear without a clock.
    reset = 1'b1;
    #1;
    total_cnt++;
    if (ttl_out !== 2'b00 || level !== 2'b00 || edge_count !== '0) begin
      $display("FAIL reset_async: ttl=%b level=%b cnt=%h required 00/00/0",
               ttl_out, level, edge_count);
    end else pass_cnt++;
    step();
    reset = 1'b0;
    repeat (3) step();
    ev(2'b11);
    total_cnt++;
    if (ttl_out !== 2'b11 || edge_count !== {4'd1, 4'd1} || hold_error !== 1'b0) begin
      $display("FAIL reset_post_event: ttl=%b cnt=%h herr=%b required 11/11/0",
               ttl_out, edge_count, hold_error);
    end else pass_cnt++;
  endtask

  task automatic test_invert();
    do_reset();
    invert = 2'b10;
    step();
    total_cnt++;
    if (ttl_out !== 2'b10) begin
      $display("FAIL invert_idle: ttl=%b required 10", ttl_out);
    end else pass_cnt++;
    ev(2'b01);
    total_cnt++;
    if (ttl_out !== 2'b11 || level !== 2'b01) begin
      $display("FAIL invert_event: ttl=%b level=%b required 11/01", ttl_out, level);
    end else pass_cnt++;
    invert = 2'b00;
    step();
    total_cnt++;
    if (ttl_out !== 2'b01) begin
      $display("FAIL invert_release: ttl=%b required 01", ttl_out);
    end else pass_cnt++;
  endtask

  task automatic test_override();
    do_reset();
    override_en = 1'b1;
    override_val = 2'b10;
    ev(2'b11);
    total_cnt++;
    if (ttl_out !== 2'b10 || level !== 2'b11 || edge_count !== {4'd1, 4'd1}) begin
      $display("FAIL override_hold: ttl=%b level=%b cnt=%h required 10/11/11",
               ttl_out, level, edge_count);
    end else pass_cnt++;
    override_en = 1'b0;
    step();
    total_cnt++;
    if (ttl_out !== 2'b11) begin
      $display("FAIL override_release: ttl=%b required 11", ttl_out);
    end else pass_cnt++;
  endtask

  task automatic test_hold_violation();
    logic [127:0] w2;
    do_reset();
    ev(2'b01);                  // cycle t
    step();                     // cycle t+1 idle
    ev(2'b00);                  // cycle t+2: too soon
    w2 = {ts, 62'd0, 2'b00};
    total_cnt++;
    if (hold_error !== 1'b1 || hold_error_data !== w2) begin
      $display("FAIL hold_violation: herr=%b hdata=%h required 1/%h",
               hold_error, hold_error_data, w2);
    end else pass_cnt++;
    step();                     // cycle t+3
    total_cnt++;
    if (hold_error !== 1'b0 || hold_error_data !== w2) begin
      $display("FAIL hold_pulse_width: herr=%b hdata=%h required 0/%h",
               hold_error, hold_error_data, w2);
    end else pass_cnt++;
    step();                     // cycle t+4
    step();                     // cycle t+5
    ev(2'b01);                  // cycle t+6: clean interval
    total_cnt++;
    if (hold_error !== 1'b0 || level !== 2'b01) begin
      $display("FAIL hold_clean: herr=%b level=%b required 0/01", hold_error, level);
    end else pass_cnt++;
    // Both channels change. Only ch0 is inside its window. One pulse results.
    ev(2'b10);
    total_cnt++;
    if (hold_error !== 1'b1 || hold_error_data !== {ts, 62'd0, 2'b10} || level !== 2'b10) begin
      $display("FAIL hold_multi: herr=%b hdata=%h level=%b required 1/latest/10",
               hold_error, hold_error_data, level);
    end else pass_cnt++;
    ev(2'b11);                  // back-to-back: ch0 changes again
    total_cnt++;
    if (hold_error !== 1'b1 || hold_error_data !== {ts, 62'd0, 2'b11}) begin
      $display("FAIL hold_back_to_back: herr=%b hdata=%h required 1/latest",
               hold_error, hold_error_data);
    end else pass_cnt++;
  endtask

  task automatic test_no_change();
    do_reset();
    ev(2'b01);                  // cycle t: ch0 window starts
    ev(2'b01);                  // cycle t+1: same level, no reload
    total_cnt++;
    if (hold_error !== 1'b0) begin
      $display("FAIL nochange_error: herr=%b required 0", hold_error);
    end else pass_cnt++;
    step();
    step();
    ev(2'b00);                  // cycle t+4: window expired if not reloaded
    total_cnt++;
    if (hold_error !== 1'b0 || level !== 2'b00) begin
      $display("FAIL nochange_reload: herr=%b level=%b required 0/00", hold_error, level);
    end else pass_cnt++;
  endtask

  task automatic test_saturation_clear();
    do_reset();
    for (int i = 0; i < 17; i++) begin
      ev(2'b01);
      ev(2'b00);
    end
    total_cnt++;
    if (edge_count[3:0] !== 4'hF || edge_count[7:4] !== 4'h0) begin
      $display("FAIL count_saturate: cnt=%h required 0F", edge_count);
    end else pass_cnt++;
    count_clear = 1'b1;
    ev(2'b01);                  // rising edge coincides with clear
    count_clear = 1'b0;
    total_cnt++;
    if (edge_count !== '0 || level !== 2'b01) begin
      $display("FAIL count_clear_wins: cnt=%h level=%b required 00/01", edge_count, level);
    end else pass_cnt++;
    ev(2'b00);
    ev(2'b11);
    total_cnt++;
    if (edge_count !== {4'd1, 4'd1}) begin
      $display("FAIL count_after_clear: cnt=%h required 11", edge_count);
    end else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_invert();
    test_override();
    test_hold_violation();
    test_no_change();
    test_saturation_clear();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/rtoc_ttl_out_driver.md
Name: rtoc_ttl_out_driver

Overview:
- Output stage directly downstream of the real-time output FIFO core.
- Consumes that core's match strobe (counter_matched) and its 128-bit output word (rto_out), and drives the physical TTL pins.
- Adds per-channel polarity inversion, a software override, a minimum-hold guard with error capture, and saturating rising-edge counters for readback.

Parameters:
DATA_LEN, 1, number of TTL channels; equals the data field width in rto_out[DATA_LEN-1:0]
MIN_HOLD, 4, minimum cycles between two logical level changes on one channel; 0 disables the guard
COUNT_WIDTH, 32, width of each per-channel rising-edge counter

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-high reset
counter_matched  input  1  one-cycle strobe; rto_out carries a due event this cycle
rto_out  input  128  event word: [127:64] timestamp, [63:DATA_LEN] zero, [DATA_LEN-1:0] channel levels
invert  input  DATA_LEN  per-channel output polarity inversion
override_en  input  1  1 = pins driven from override_val
override_val  input  DATA_LEN  physical pin levels while override_en=1
count_clear  input  1  synchronous clear of all edge counters
ttl_out  output  DATA_LEN  registered physical TTL pin levels
level  output  DATA_LEN  scheduled logical level, pre-invert, unaffected by override
edge_count  output  DATA_LEN*COUNT_WIDTH  flattened counters, channel c at [c*COUNT_WIDTH +: COUNT_WIDTH]
hold_error  output  1  one-cycle pulse on a minimum-hold violation
hold_error_data  output  128  rto_out word of the most recent violating event

Behaviour:
- Reset (asynchronous assert, release on a clk edge): ttl_out=0, level=0, all edge_count=0, hold_error=0, hold_error_data=0, all hold counters=0.
- In the first cycle after reset, ttl_out takes the value given by the rules below; that is invert^0 if override_en=0.
- Event: counter_matched=1 in cycle t.
  - level <= rto_out[DATA_LEN-1:0] at edge t+1; latency 1.
  - With counter_matched=0, level holds.
- ttl_out register, updated every cycle:
  - override_en=1: ttl_out <= override_val.
  - override_en=0: ttl_out <= next_level ^ invert, where next_level is the value level takes at the same edge.
  - Result: event-to-pin latency is 1 cycle, the same as level.
- Override:
  - Does not block event processing; level, the counters and the guard keep tracking the schedule.
  - On release, ttl_out = level ^ invert at the next edge.
- invert changes take effect at the next edge, with no event needed.
- Hold guard, per channel c, using a counter hold_cnt[c] of width clog2(MIN_HOLD+1):
  - An event changes channel c when rto_out[c] != level[c].
  - On a change: hold_cnt[c] <= MIN_HOLD-1. Otherwise, if hold_cnt[c]!=0, it decrements by 1.
  - A change on c with hold_cnt[c]!=0 is a violation. The change is still applied.
  - On any violation: hold_error=1 for exactly one cycle (edge t+1), and hold_error_data <= rto_out (full 128 bits).
  - Multiple violating channels in one event give a single pulse.
  - Back-to-back violations give consecutive pulses, and hold_error_data holds the latest word.
  - An event with no level change never reloads a counter and never errors.
  - MIN_HOLD=0: guard disabled, hold_error stays 0.
- Edge counters, per channel:
  - Increment when level[c] goes 0->1. Logical, so unaffected by invert and override.
  - Saturate at all-ones; no wrap.
  - count_clear=1 sets every counter to 0 at the next edge; clear wins over a same-cycle rising edge (result 0).
- Holding counter_matched high for several cycles is legal; each cycle counts as a separate event.

Test Plan:
- Reset mid-operation: DATA_LEN=2, invert=2'b00, events at cycles 10 (levels 2'b01) and 20 (2'b11); assert reset at cycle 15 -> ttl_out, level, and counters are 0 immediately; the cycle-20 event gives ttl_out=2'b11 at cycle 21 with edge_count ch1=1, ch0=1.
- Invert and latency: invert=2'b10, event 2'b01 at cycle t -> ttl_out=2'b11 at t+1; then invert=2'b00 with no event -> ttl_out=2'b01 the next cycle.
- Override: override_en=1 with override_val=2'b10, event 2'b11 -> ttl_out stays 2'b10 and level=2'b11; release override -> ttl_out=2'b11 one cycle later.
- Hold violation: MIN_HOLD=4, ch0 changes at cycle t and again at t+2 -> hold_error pulses at t+3 and hold_error_data equals the second rto_out word; a change at t+6 after a clean interval -> no error.
- No-change event: an event repeating the current levels inside the hold window -> no hold_error and no hold counter reload.
- Counter saturation and clear: COUNT_WIDTH=4, 17 rising edges on ch0 -> edge_count ch0=4'hF; count_clear coincident with a rising edge -> 0.
